// File: rtl/sobel_pkg.sv
// Shared widths, window layout and helpers for the Sobel window engine.
// Window index convention: w[r][c], r=0 is the top row, c=2 the newest column.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int SUM_W   = 10;
  localparam int GRAD_W  = 11;
  localparam int MAG_MAX = 255;

  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  // 1-2-1 weighted sum of three pixels
  function automatic logic [SUM_W-1:0] psum(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b,
    input logic [PIX_W-1:0] c
  );
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

endpackage

// File: rtl/sobel_grad_pipe.sv
// Three-stage Sobel arithmetic: partial sums, |Gx|+|Gy|, saturation and threshold.
// Stages advance every cycle; valid and done tags ride alongside the data.
module sobel_grad_pipe
  import sobel_pkg::*;
#(
  parameter int THRESHOLD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  win_t             win,
  input  logic             win_v,
  input  logic             win_done,
  output logic [PIX_W-1:0] mag,
  output logic             edge_hit,
  output logic             mag_v,
  output logic             mag_done
);

  localparam logic [PIX_W-1:0]  THR = PIX_W'(THRESHOLD);
  localparam logic [GRAD_W-1:0] SAT = GRAD_W'(MAG_MAX);

  logic [SUM_W-1:0]  gx_p, gx_n, gy_p, gy_n;
  logic              s1_v, s1_d;
  logic [GRAD_W-1:0] s2_sum;
  logic              s2_v, s2_d;

  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0]        ax, ay, abs_sum;
  logic [PIX_W-1:0]         sat_mag;

  always_comb begin
    gx      = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
    gy      = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
    ax      = gx[GRAD_W-1] ? (~gx + GRAD_W'(1)) : gx;
    ay      = gy[GRAD_W-1] ? (~gy + GRAD_W'(1)) : gy;
    abs_sum = ax + ay;
    sat_mag = (s2_sum > SAT) ? PIX_W'(MAG_MAX) : s2_sum[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p     <= '0;
      gx_n     <= '0;
      gy_p     <= '0;
      gy_n     <= '0;
      s1_v     <= 1'b0;
      s1_d     <= 1'b0;
      s2_sum   <= '0;
      s2_v     <= 1'b0;
      s2_d     <= 1'b0;
      mag      <= '0;
      edge_hit <= 1'b0;
      mag_v    <= 1'b0;
      mag_done <= 1'b0;
    end else begin
      gx_p     <= psum(win[0][2], win[1][2], win[2][2]);
      gx_n     <= psum(win[0][0], win[1][0], win[2][0]);
      gy_p     <= psum(win[2][0], win[2][1], win[2][2]);
      gy_n     <= psum(win[0][0], win[0][1], win[0][2]);
      s1_v     <= win_v;
      s1_d     <= win_done;
      s2_sum   <= abs_sum;
      s2_v     <= s1_v;
      s2_d     <= s1_d;
      mag      <= sat_mag;
      edge_hit <= sat_mag >= THR;
      mag_v    <= s2_v;
      mag_done <= s2_d;
    end
  end

endmodule

// File: rtl/sobel_window_engine.sv
// 3x3 window assembly with row/column tracking; border windows never leave here.
// Feeds the Sobel gradient pipe and tags the last interior window of a frame.
module sobel_window_engine
  import sobel_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 128,
  parameter int THRESHOLD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof_i,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [PIX_W-1:0] row1_i,
  input  logic [PIX_W-1:0] row2_i,
  output logic             valid_o,
  output logic [PIX_W-1:0] mag_o,
  output logic             edge_o,
  output logic             frame_done_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic          col_last, row_last, interior;
  win_t          win;
  logic          win_v, win_done;

  // sof overrides the running position, so the accepted pixel is (0,0)
  always_comb begin
    cur_col  = sof_i ? '0 : col_cnt;
    cur_row  = sof_i ? '0 : row_cnt;
    col_last = cur_col == CW'(WIDTH - 1);
    row_last = cur_row == RW'(HEIGHT - 1);
    interior = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      win      <= '0;
      win_v    <= 1'b0;
      win_done <= 1'b0;
    end else begin
      win_v    <= valid_i && interior;
      win_done <= valid_i && interior && col_last && row_last;
      if (valid_i) begin
        col_cnt <= col_last ? '0 : cur_col + CW'(1);
        if (col_last)
          row_cnt <= row_last ? '0 : cur_row + RW'(1);
        else
          row_cnt <= cur_row;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= row2_i;
        win[1][2] <= row1_i;
        win[2][2] <= pix_i;
      end
    end
  end

  sobel_grad_pipe #(
    .THRESHOLD(THRESHOLD)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .win      (win),
    .win_v    (win_v),
    .win_done (win_done),
    .mag      (mag_o),
    .edge_hit (edge_o),
    .mag_v    (valid_o),
    .mag_done (frame_done_o)
  );

endmodule

// File: tb/tb_sobel_window_engine.sv
// Scoreboard bench for sobel_window_engine on a 6x6 frame.
// Stimulus pushes expected windows; a negedge monitor pops and compares.
module tb_sobel_window_engine;

  localparam int W = 6;
  localparam int H = 6;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic [7:0] row1_i = '0;
  logic [7:0] row2_i = '0;
  logic       valid_o;
  logic [7:0] mag_o;
  logic       edge_o;
  logic       frame_done_o;

  sobel_window_engine #(
    .WIDTH(W), .HEIGHT(H), .THRESHOLD(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof_i        (sof_i),
    .valid_i      (valid_i),
    .pix_i        (pix_i),
    .row1_i       (row1_i),
    .row2_i       (row2_i),
    .valid_o      (valid_o),
    .mag_o        (mag_o),
    .edge_o       (edge_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] mag;
    logic       edg;
    logic       done;
    int         t;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int outs = 0;
  int dones = 0;
  int o0 = 0;
  int d0 = 0;
  logic [7:0] img [H][W];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done_o && !valid_o) begin
        tests++;
        fails++;
        $display("FAIL done_without_valid at cycle %0d", cyc);
      end
      if (valid_o) begin
        outs++;
        if (frame_done_o) dones++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: mag %0d at cycle %0d, none expected", mag_o, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (mag_o !== e.mag || edge_o !== e.edg ||
              frame_done_o !== e.done || cyc != e.t) begin
            fails++;
            $display("FAIL output: got mag %0d edge %0b done %0b cyc %0d, expected mag %0d edge %0b done %0b cyc %0d",
                     mag_o, edge_o, frame_done_o, cyc, e.mag, e.edg, e.done, e.t);
          end
        end
      end
    end
  end

  function automatic exp_t model(input int r, input int c);
    int gx, gy, m;
    exp_t e;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    e.mag  = 8'(m);
    e.edg  = (m >= T);
    e.done = (r == H-1) && (c == W-1);
    e.t    = 0;
    return e;
  endfunction

  task automatic send(input int r, input int c, input bit sof);
    exp_t e;
    @(negedge clk);
    valid_i = 1'b1;
    sof_i   = sof;
    pix_i   = img[r][c];
    row1_i  = (r >= 1) ? img[r-1][c] : 8'($urandom);
    row2_i  = (r >= 2) ? img[r-2][c] : 8'($urandom);
    if (r >= 2 && c >= 2) begin
      e   = model(r, c);
      e.t = cyc + 4;
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    sof_i   = 1'b0;
    pix_i   = 8'($urandom);
    row1_i  = 8'($urandom);
    row2_i  = 8'($urandom);
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 8'd77;
          1: img[r][c] = (c < 3) ? 8'd0 : 8'd255;
          2: img[r][c] = (r < 3) ? 8'd10 : 8'd60;
          default: img[r][c] = (r == 0) ? 8'd255 : 8'd0;
        endcase
  endtask

  task automatic frame(input int kind, input bit sof, input bit alt);
    fill(kind);
    o0 = outs;
    d0 = dones;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c, sof && r == 0 && c == 0);
        if (alt) idle();
      end
  endtask

  task automatic finish_frame(input string nm, input int n_out, input int n_done);
    idle();
    repeat (6) @(negedge clk);
    chk({nm, "_count"}, outs - o0, n_out);
    chk({nm, "_done"}, dones - d0, n_done);
    chk({nm, "_pending"}, sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_valid", valid_o, 0);
    chk("reset_mag", mag_o, 0);
    chk("reset_edge", edge_o, 0);
    chk("reset_done", frame_done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(0, 1'b1, 1'b0);
    finish_frame("flat", 16, 1);
    frame(1, 1'b1, 1'b0);
    finish_frame("vstep", 16, 1);
    frame(2, 1'b1, 1'b0);
    finish_frame("hstep", 16, 1);
    frame(1, 1'b1, 1'b1);
    finish_frame("vstep_alt", 16, 1);

    fill(1);
    o0 = outs;
    d0 = dones;
    for (int n = 0; n < 3*W + 5; n++)
      send(n / W, n % W, n == 0);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    #1;
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_mag", mag_o, 0);
    chk("rst_mid_edge", edge_o, 0);
    chk("rst_mid_done", frame_done_o, 0);
    chk("rst_mid_no_frame_done", dones - d0, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    frame(2, 1'b0, 1'b0);
    finish_frame("after_reset", 16, 1);
    frame(3, 1'b1, 1'b0);
    finish_frame("overflow", 16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
